dram_slot_sched: RTL and testbench
==================================

# dram_slot_sched

Per-cycle DRAM scheduler sharing the single 16-bit DRAM channel between three requesters: video fetch, Z80 memory (`zmem` CPU port) and a new 16-bit DMA engine (SD/IDE-to-RAM). It sits between the requesters and the `dram` controller, replacing the two-way `arbiter` path. It makes one ownership decision per DRAM cycle (`cbeg`), drives the command, and routes `dram_rrdy`/`dram_rddata` back to the requester that owns the executing cycle.

## Interface
Parameters:
- `ADDR_W`, 21, DRAM word address width
- `STARVE_MAX`, 15, consecutive lost decisions after which DMA outranks CPU (1..255)

Ports:
- `fclk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `cbeg` in 1: DRAM cycle-begin pulse (one fclk wide); one decision per pulse
- `dram_req` out 1, `dram_rnw` out 1, `dram_addr` out ADDR_W, `dram_bsel` out 2, `dram_wrdata` out 16: command to DRAM controller
- `dram_rrdy` in 1, `dram_rddata` in 16: read-data-valid pulse and data for the executing cycle
- `vid_req` in 1, `vid_addr` in ADDR_W: video fetch request (always read)
- `vid_ack` out 1, `vid_strobe` out 1, `vid_data` out 16
- `cpu_req` in 1, `cpu_rnw` in 1, `cpu_addr` in ADDR_W, `cpu_wrbsel` in 1, `cpu_wrdata` in 8
- `cpu_ack` out 1, `cpu_strobe` out 1, `cpu_rddata` out 16
- `dma_req` in 1, `dma_rnw` in 1, `dma_addr` in ADDR_W, `dma_wrdata` in 16
- `dma_ack` out 1, `dma_strobe` out 1, `dma_rddata` out 16
- `owner` out 2: owner of the command now presented (0 idle, 1 video, 2 cpu, 3 dma)

## Operation
- Decision at each `cbeg`. Priority: video > DMA (if `starve_cnt == STARVE_MAX`) > CPU > DMA > idle.
- Winner's request is latched into the command stage: `dram_req=1`, address/rnw/data copied. `owner` = winner. The winner's `*_ack` pulses for that same fclk (the `cbeg` cycle). The requester advances or drops `*_req` on ack. A request seen with ack is never re-served.
- Byte select: video/DMA `11`. CPU write: `cpu_wrbsel ? 10 : 01`, `dram_wrdata = {cpu_wrdata,cpu_wrdata}`. CPU read: `11`.
- Idle decision: `dram_req=0`, `owner=0`. The controller uses that cycle for refresh.
- `starve_cnt` (8 bits): at `cbeg` with `dma_req=1` and DMA not granted, increment, saturating at `STARVE_MAX`. It clears on DMA grant or when `dma_req=0`.
- Execute stage: at each `cbeg`, `exec_owner <= owner`, `exec_rnw <= dram_rnw` (idle if `dram_req=0`). This happens before the command stage is overwritten.
- `dram_rrdy` with `exec_rnw=1` pulses the `exec_owner` strobe for 1 fclk. The matching `*_data` register loads `dram_rddata` and holds until the next strobe to the same requester.
- `dram_rrdy` with `exec_owner` idle or a write is ignored.

## Timing
- Reset values: all outputs 0, `owner=0`, `exec_owner=0`, `starve_cnt=0`, data registers 0.
- Request sampled at `cbeg` N. The command is valid from N+1 fclk to the next `cbeg` (N'), where the controller samples it. Read data arrives with `dram_rrdy` inside cycle N'..N''. Read latency is therefore one DRAM cycle plus controller latency.
- Write completion is implied by ack; writes produce no strobe.
- `cbeg` and `dram_rrdy` in the same fclk: the rrdy is routed using the pre-update `exec_owner`.
- `cbeg` with no requests: the previous command is dropped; `dram_req` deasserts in the next fclk.
- Requests must be held stable until ack. Request changes between `cbeg` pulses have no effect.
- Reset mid-operation: pending strobes are lost, and no strobe or ack is issued after reset until a new grant.

## Structure
- Shared package `dram_pkg`: owner encoding (`OWN_IDLE=0`, `OWN_VID=1`, `OWN_CPU=2`, `OWN_DMA=3`) and `ADDR_W` default. The existing `arbiter` and `dram` blocks reuse these.
- One sub-module, `starve_ctr`: saturating counter with grant/req inputs and a `starved` output.
- Priority selection and command/execute registers stay in the top of the block.

## Test plan
- Reset during a CPU read (`rst` pulse between grant and `dram_rrdy`) -> no `cpu_strobe`; all outputs 0; next `cbeg` with `cpu_req` grants normally.
- `vid_req` and `cpu_req` both high at `cbeg` -> `vid_ack` only, `owner=1`; next `cbeg` (vid dropped) -> `cpu_ack`, `owner=2`.
- CPU byte write `cpu_addr=0x12345`, `cpu_wrbsel=1`, `cpu_wrdata=0xA5` -> `dram_addr=0x12345`, `dram_rnw=0`, `dram_bsel=10`, `dram_wrdata=0xA5A5`; no strobe.
- Continuous `cpu_req`+`dma_req`, `STARVE_MAX=15` -> CPU wins 15 decisions, DMA wins the 16th, counter returns to 0; the pattern repeats.
- DMA read granted, then `dram_rrdy` with `dram_rddata=0xBEEF` coincident with the next `cbeg` -> `dma_strobe=1`, `dma_rddata=0xBEEF`; `cpu_strobe` and `vid_strobe` stay 0.
- No requests for 3 `cbeg` -> `dram_req=0`, `owner=0`; a stray `dram_rrdy` produces no strobe.

Source files
------------

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - owner encoding and address width shared by the DRAM path blocks
package dram_pkg;

  localparam int DRAM_ADDR_W = 21;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  localparam logic [1:0] BSEL_WORD = 2'b11;
  localparam logic [1:0] BSEL_HI   = 2'b10;
  localparam logic [1:0] BSEL_LO   = 2'b01;

endpackage

// File: rtl/starve_ctr.sv
// rtl/starve_ctr.sv - counts consecutive DMA decisions lost; saturates and flags starvation
module starve_ctr #(
  parameter int STARVE_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic req,
  input  logic grant,
  output logic starved
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      if (!req || grant) begin
        cnt_d = '0;
      end else if (cnt_q != 8'(STARVE_MAX)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (cnt_q == 8'(STARVE_MAX));

endmodule

// File: rtl/dram_slot_sched.sv
// rtl/dram_slot_sched.sv - per-cbeg ownership of the DRAM channel among video, CPU and DMA
module dram_slot_sched
  import dram_pkg::*;
#(
  parameter int ADDR_W     = DRAM_ADDR_W,
  parameter int STARVE_MAX = 15
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              cbeg,
  output logic              dram_req,
  output logic              dram_rnw,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [1:0]        dram_bsel,
  output logic [15:0]       dram_wrdata,
  input  logic              dram_rrdy,
  input  logic [15:0]       dram_rddata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_strobe,
  output logic [15:0]       vid_data,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wrbsel,
  input  logic [7:0]        cpu_wrdata,
  output logic              cpu_ack,
  output logic              cpu_strobe,
  output logic [15:0]       cpu_rddata,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [15:0]       dma_wrdata,
  output logic              dma_ack,
  output logic              dma_strobe,
  output logic [15:0]       dma_rddata,
  output logic [1:0]        owner
);

  owner_e            win;
  logic              starved;
  logic              grant_en;

  owner_e            owner_q, owner_d;
  logic              cmd_req_q, cmd_req_d;
  logic              cmd_rnw_q, cmd_rnw_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [1:0]        cmd_bsel_q, cmd_bsel_d;
  logic [15:0]       cmd_wrdata_q, cmd_wrdata_d;
  owner_e            exec_owner_q, exec_owner_d;
  logic              exec_rnw_q, exec_rnw_d;

  logic              vid_stb_q, vid_stb_d, cpu_stb_q, cpu_stb_d, dma_stb_q, dma_stb_d;
  logic [15:0]       vid_data_q, vid_data_d, cpu_data_q, cpu_data_d, dma_data_q, dma_data_d;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (fclk),
    .rst     (rst),
    .step    (cbeg),
    .req     (dma_req),
    .grant   (win == OWN_DMA),
    .starved (starved)
  );

  always_comb begin
    win = OWN_IDLE;
    if (vid_req)                  win = OWN_VID;
    else if (dma_req && starved)  win = OWN_DMA;
    else if (cpu_req)             win = OWN_CPU;
    else if (dma_req)             win = OWN_DMA;
  end

  // Acks are combinational so the requester sees them in the cbeg cycle itself.
  assign grant_en = cbeg && !rst;
  assign vid_ack  = grant_en && (win == OWN_VID);
  assign cpu_ack  = grant_en && (win == OWN_CPU);
  assign dma_ack  = grant_en && (win == OWN_DMA);

  always_comb begin
    owner_d      = owner_q;
    cmd_req_d    = cmd_req_q;
    cmd_rnw_d    = cmd_rnw_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_bsel_d   = cmd_bsel_q;
    cmd_wrdata_d = cmd_wrdata_q;
    exec_owner_d = exec_owner_q;
    exec_rnw_d   = exec_rnw_q;
    if (cbeg) begin
      exec_owner_d = cmd_req_q ? owner_q : OWN_IDLE;
      exec_rnw_d   = cmd_req_q && cmd_rnw_q;
      owner_d      = win;
      cmd_req_d    = (win != OWN_IDLE);
      cmd_rnw_d    = 1'b0;
      cmd_addr_d   = '0;
      cmd_bsel_d   = 2'b00;
      cmd_wrdata_d = '0;
      case (win)
        OWN_VID: begin
          cmd_rnw_d  = 1'b1;
          cmd_addr_d = vid_addr;
          cmd_bsel_d = BSEL_WORD;
        end
        OWN_CPU: begin
          cmd_rnw_d    = cpu_rnw;
          cmd_addr_d   = cpu_addr;
          cmd_bsel_d   = cpu_rnw ? BSEL_WORD : (cpu_wrbsel ? BSEL_HI : BSEL_LO);
          cmd_wrdata_d = {cpu_wrdata, cpu_wrdata};
        end
        OWN_DMA: begin
          cmd_rnw_d    = dma_rnw;
          cmd_addr_d   = dma_addr;
          cmd_bsel_d   = BSEL_WORD;
          cmd_wrdata_d = dma_wrdata;
        end
        default: ;
      endcase
    end
  end

  // exec_* holds pre-update values here, so an rrdy coincident with cbeg goes to the old cycle.
  always_comb begin
    vid_stb_d  = 1'b0;
    cpu_stb_d  = 1'b0;
    dma_stb_d  = 1'b0;
    vid_data_d = vid_data_q;
    cpu_data_d = cpu_data_q;
    dma_data_d = dma_data_q;
    if (dram_rrdy && exec_rnw_q) begin
      case (exec_owner_q)
        OWN_VID: begin vid_stb_d = 1'b1; vid_data_d = dram_rddata; end
        OWN_CPU: begin cpu_stb_d = 1'b1; cpu_data_d = dram_rddata; end
        OWN_DMA: begin dma_stb_d = 1'b1; dma_data_d = dram_rddata; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_IDLE;
      cmd_req_q    <= 1'b0;
      cmd_rnw_q    <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_bsel_q   <= 2'b00;
      cmd_wrdata_q <= '0;
      exec_owner_q <= OWN_IDLE;
      exec_rnw_q   <= 1'b0;
      vid_stb_q    <= 1'b0;
      cpu_stb_q    <= 1'b0;
      dma_stb_q    <= 1'b0;
      vid_data_q   <= '0;
      cpu_data_q   <= '0;
      dma_data_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      cmd_req_q    <= cmd_req_d;
      cmd_rnw_q    <= cmd_rnw_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_bsel_q   <= cmd_bsel_d;
      cmd_wrdata_q <= cmd_wrdata_d;
      exec_owner_q <= exec_owner_d;
      exec_rnw_q   <= exec_rnw_d;
      vid_stb_q    <= vid_stb_d;
      cpu_stb_q    <= cpu_stb_d;
      dma_stb_q    <= dma_stb_d;
      vid_data_q   <= vid_data_d;
      cpu_data_q   <= cpu_data_d;
      dma_data_q   <= dma_data_d;
    end
  end

  assign owner       = owner_q;
  assign dram_req    = cmd_req_q;
  assign dram_rnw    = cmd_rnw_q;
  assign dram_addr   = cmd_addr_q;
  assign dram_bsel   = cmd_bsel_q;
  assign dram_wrdata = cmd_wrdata_q;
  assign vid_strobe  = vid_stb_q;
  assign cpu_strobe  = cpu_stb_q;
  assign dma_strobe  = dma_stb_q;
  assign vid_data    = vid_data_q;
  assign cpu_rddata  = cpu_data_q;
  assign dma_rddata  = dma_data_q;

endmodule

// File: tb/tb_dram_slot_sched.sv
// tb/tb_dram_slot_sched.sv - directed and randomized checks of dram_slot_sched against a behavioural model
module tb_dram_slot_sched;

  localparam int AW   = 21;
  localparam int SMAX = 15;

  logic          fclk = 1'b0;
  logic          rst, cbeg, dram_rrdy;
  logic [15:0]   dram_rddata;
  logic          dram_req, dram_rnw;
  logic [AW-1:0] dram_addr;
  logic [1:0]    dram_bsel;
  logic [15:0]   dram_wrdata;
  logic          vid_req, vid_ack, vid_strobe;
  logic [AW-1:0] vid_addr;
  logic [15:0]   vid_data;
  logic          cpu_req, cpu_rnw, cpu_wrbsel, cpu_ack, cpu_strobe;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wrdata;
  logic [15:0]   cpu_rddata;
  logic          dma_req, dma_rnw, dma_ack, dma_strobe;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_wrdata, dma_rddata;
  logic [1:0]    owner;

  always #5 fclk = ~fclk;

  dram_slot_sched #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .fclk(fclk), .rst(rst), .cbeg(cbeg),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_bsel(dram_bsel), .dram_wrdata(dram_wrdata),
    .dram_rrdy(dram_rrdy), .dram_rddata(dram_rddata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_strobe(vid_strobe), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata), .cpu_ack(cpu_ack),
    .cpu_strobe(cpu_strobe), .cpu_rddata(cpu_rddata),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
    .dma_wrdata(dma_wrdata), .dma_ack(dma_ack), .dma_strobe(dma_strobe),
    .dma_rddata(dma_rddata), .owner(owner)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the command being presented, the cycle executing, per-requester strobe/data, lost-decision count.
  bit            m_req, m_rnw, m_er;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_bsel;
  logic [15:0]   m_wd;
  int            m_own, m_eo, m_cnt, last_win;
  bit            m_stb[4];
  logic [15:0]   m_dat[4];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_rnw = 0; m_er = 0; m_addr = '0; m_bsel = 0; m_wd = 0;
    m_own = 0; m_eo = 0; m_cnt = 0; last_win = 0;
    for (int i = 0; i < 4; i++) begin m_stb[i] = 0; m_dat[i] = 0; end
  endtask

  function automatic int pick();
    if (vid_req) return 1;
    if (dma_req && m_cnt >= SMAX) return 3;
    if (cpu_req) return 2;
    if (dma_req) return 3;
    return 0;
  endfunction

  task automatic check();
    int w;
    if (rst) model_reset();
    w = (cbeg && !rst) ? pick() : 0;
    cmp("vid_ack", 32'(vid_ack), 32'(w == 1));
    cmp("cpu_ack", 32'(cpu_ack), 32'(w == 2));
    cmp("dma_ack", 32'(dma_ack), 32'(w == 3));
    cmp("dram_req", 32'(dram_req), 32'(m_req));
    cmp("dram_rnw", 32'(dram_rnw), 32'(m_rnw));
    cmp("dram_addr", 32'(dram_addr), 32'(m_addr));
    cmp("dram_bsel", 32'(dram_bsel), 32'(m_bsel));
    cmp("dram_wrdata", 32'(dram_wrdata), 32'(m_wd));
    cmp("owner", 32'(owner), m_own);
    cmp("vid_strobe", 32'(vid_strobe), 32'(m_stb[1]));
    cmp("cpu_strobe", 32'(cpu_strobe), 32'(m_stb[2]));
    cmp("dma_strobe", 32'(dma_strobe), 32'(m_stb[3]));
    cmp("vid_data", 32'(vid_data), 32'(m_dat[1]));
    cmp("cpu_rddata", 32'(cpu_rddata), 32'(m_dat[2]));
    cmp("dma_rddata", 32'(dma_rddata), 32'(m_dat[3]));
  endtask

  task automatic model_update();
    int w;
    if (rst) begin model_reset(); return; end
    for (int i = 1; i < 4; i++) m_stb[i] = 0;
    if (dram_rrdy && m_er && m_eo != 0) begin
      m_stb[m_eo] = 1;
      m_dat[m_eo] = dram_rddata;
    end
    last_win = 0;
    if (cbeg) begin
      w = pick();
      last_win = w;
      m_eo = m_req ? m_own : 0;
      m_er = m_req && m_rnw;
      if (dma_req && w != 3) m_cnt = (m_cnt < SMAX) ? m_cnt + 1 : SMAX;
      else m_cnt = 0;
      m_req = (w != 0);
      m_own = w;
      m_rnw = 0; m_addr = '0; m_bsel = 0; m_wd = 0;
      if (w == 1) begin
        m_rnw = 1; m_addr = vid_addr; m_bsel = 3;
      end else if (w == 2) begin
        m_rnw = cpu_rnw; m_addr = cpu_addr; m_wd = {cpu_wrdata, cpu_wrdata};
        m_bsel = cpu_rnw ? 2'd3 : (cpu_wrbsel ? 2'd2 : 2'd1);
      end else if (w == 3) begin
        m_rnw = dma_rnw; m_addr = dma_addr; m_bsel = 3; m_wd = dma_wrdata;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check();
    @(posedge fclk);
    model_update();
    @(negedge fclk);
  endtask

  task automatic pulse_cbeg();
    cbeg = 1; cycle();
    cbeg = 0; cycle();
  endtask

  initial begin
    rst = 1; cbeg = 0; dram_rrdy = 0; dram_rddata = 0;
    vid_req = 0; vid_addr = 0;
    cpu_req = 0; cpu_rnw = 0; cpu_addr = 0; cpu_wrbsel = 0; cpu_wrdata = 0;
    dma_req = 0; dma_rnw = 0; dma_addr = 0; dma_wrdata = 0;
    model_reset();
    @(negedge fclk);
    cycle(); cycle();
    rst = 0;
    cycle();
    cmp("rst_owner", 32'(owner), 0);
    cmp("rst_dram_req", 32'(dram_req), 0);

    // video beats CPU, then CPU is served next
    vid_req = 1; vid_addr = 21'h0ABCD;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h00100;
    cbeg = 1;
    #1;
    cmp("both_vid_ack", 32'(vid_ack), 1);
    cmp("both_cpu_ack", 32'(cpu_ack), 0);
    cycle();
    cmp("vid_owner", 32'(owner), 1);
    cmp("vid_addr_out", 32'(dram_addr), 32'h0ABCD);
    vid_req = 0; cbeg = 0; cycle();
    cbeg = 1;
    #1;
    cmp("next_cpu_ack", 32'(cpu_ack), 1);
    cycle();
    cmp("cpu_owner", 32'(owner), 2);
    cpu_req = 0; cbeg = 0; cycle();

    // CPU byte write
    cpu_req = 1; cpu_rnw = 0; cpu_addr = 21'h12345; cpu_wrbsel = 1; cpu_wrdata = 8'hA5;
    cbeg = 1; cycle();
    cmp("wr_addr", 32'(dram_addr), 32'h12345);
    cmp("wr_rnw", 32'(dram_rnw), 0);
    cmp("wr_bsel", 32'(dram_bsel), 32'h2);
    cmp("wr_data", 32'(dram_wrdata), 32'hA5A5);
    cpu_req = 0; cbeg = 0; cycle();
    pulse_cbeg();
    cbeg = 1; dram_rrdy = 1; dram_rddata = 16'h5555; cycle();
    cmp("wr_no_strobe", 32'(cpu_strobe), 0);
    cbeg = 0; dram_rrdy = 0; cycle();

    // DMA read; data returns at the cbeg ending its execute cycle
    dma_req = 1; dma_rnw = 1; dma_addr = 21'h00777;
    cbeg = 1; cycle();
    cmp("dma_owner", 32'(owner), 3);
    dma_req = 0; cbeg = 0; cycle();
    pulse_cbeg();
    cbeg = 1; dram_rrdy = 1; dram_rddata = 16'hBEEF; cycle();
    cmp("dma_strobe_lit", 32'(dma_strobe), 1);
    cmp("dma_rddata_lit", 32'(dma_rddata), 32'hBEEF);
    cmp("dma_cpu_strobe", 32'(cpu_strobe), 0);
    cmp("dma_vid_strobe", 32'(vid_strobe), 0);
    cbeg = 0; dram_rrdy = 0; cycle();

    // reset between CPU read grant and its data
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h00200;
    cbeg = 1; cycle();
    cpu_req = 0; cbeg = 0; cycle();
    cbeg = 1; cycle();
    cbeg = 0; rst = 1; cycle();
    cmp("rstmid_req", 32'(dram_req), 0);
    cmp("rstmid_owner", 32'(owner), 0);
    rst = 0; dram_rrdy = 1; dram_rddata = 16'h1234; cycle();
    dram_rrdy = 0;
    cmp("rstmid_no_strobe", 32'(cpu_strobe), 0);
    cmp("rstmid_data", 32'(cpu_rddata), 0);
    cycle();
    cpu_req = 1; cbeg = 1;
    #1;
    cmp("rstmid_regrant", 32'(cpu_ack), 1);
    cycle();
    cpu_req = 0; cbeg = 0; cycle();

    // starvation: 15 CPU wins, then DMA, repeating
    cpu_req = 1; cpu_rnw = 1; dma_req = 1; dma_rnw = 1;
    for (int k = 0; k < 32; k++) begin
      cbeg = 1;
      #1;
      cmp($sformatf("starve_dma_%0d", k), 32'(dma_ack), 32'((k % 16) == 15));
      cycle();
      cbeg = 0; cycle();
    end
    cpu_req = 0; dma_req = 0;

    // idle decisions and a stray rrdy
    pulse_cbeg(); pulse_cbeg(); pulse_cbeg();
    cmp("idle_req", 32'(dram_req), 0);
    cmp("idle_owner", 32'(owner), 0);
    dram_rrdy = 1; cycle();
    dram_rrdy = 0;
    cmp("stray_vid", 32'(vid_strobe), 0);
    cmp("stray_cpu", 32'(cpu_strobe), 0);
    cmp("stray_dma", 32'(dma_strobe), 0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (!vid_req && $urandom_range(0, 3) == 0) begin
        vid_req = 1; vid_addr = 21'($urandom);
      end
      if (!cpu_req && $urandom_range(0, 1) == 1) begin
        cpu_req = 1; cpu_rnw = 1'($urandom); cpu_addr = 21'($urandom);
        cpu_wrbsel = 1'($urandom); cpu_wrdata = 8'($urandom);
      end
      if (!dma_req && $urandom_range(0, 1) == 1) begin
        dma_req = 1; dma_rnw = 1'($urandom); dma_addr = 21'($urandom);
        dma_wrdata = 16'($urandom);
      end
      cbeg = !cbeg && ($urandom_range(0, 2) == 0);
      dram_rrdy = ($urandom_range(0, 3) == 0);
      dram_rddata = 16'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
      if (last_win == 1) vid_req = 0;
      if (last_win == 2) cpu_req = 0;
      if (last_win == 3) dma_req = 0;
    end
    rst = 0; cbeg = 0; dram_rrdy = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
